// File: rtl/mlp_output_neuron_mac.sv
// Output-layer MAC neuron for the O/X detector MLP.
// Serial multiply-accumulate, bias add, rescale and saturate to the score.
module mlp_output_neuron_mac #(
  parameter int N_IN        = 16,
  parameter int ACT_W       = 8,
  parameter int WGT_W       = 8,
  parameter int BIAS_W      = 16,
  parameter int ACC_W       = 24,
  parameter int SCALE_SHIFT = 6,
  parameter int OUT_W       = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [ACT_W-1:0]  in_act,
  input  logic signed [WGT_W-1:0]  in_wgt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  z,
  output logic                     sat,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    HOLD
  } state_t;

  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = ACT_W + WGT_W + 1;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] Z_MAX =
    SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Z_MIN =
    SUM_W'(-(1 << (OUT_W - 1)));

  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic signed [BIAS_W-1:0] bias_r;

  logic                     beat;
  logic                     last_beat;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  s;
  logic signed [OUT_W-1:0]  z_next;
  logic                     sat_next;

  // in_ready is high exactly while in ACCUM, so it qualifies the beat
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == CNT_W'(N_IN - 1));
  assign busy      = (state != IDLE);

  // Activation is unsigned: a zero MSB keeps the product signed-correct
  assign prod     = $signed({1'b0, in_act}) * $signed(in_wgt);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // One guard bit keeps acc + bias from wrapping
  assign sum = {acc[ACC_W-1], acc}
             + {{(SUM_W - BIAS_W){bias_r[BIAS_W-1]}}, bias_r};
  assign s   = sum >>> SCALE_SHIFT;

  // Clip the floored score into the signed OUT_W range
  always_comb begin
    z_next   = s[OUT_W-1:0];
    sat_next = 1'b0;
    if (s > Z_MAX) begin
      z_next   = {1'b0, {(OUT_W - 1){1'b1}}};
      sat_next = 1'b1;
    end else if (s < Z_MIN) begin
      z_next   = {1'b1, {(OUT_W - 1){1'b0}}};
      sat_next = 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = FINISH;
      FINISH:  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Accumulator, beat counter and captured bias
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      bias_r <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      cnt    <= '0;
      bias_r <= bias;
    end else if (beat) begin
      acc <= acc + prod_ext;
      cnt <= cnt + 1'b1;
    end
  end

  // Registered handshake flags follow the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == HOLD);
    end
  end

  // Result registers load once in FINISH and hold afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z   <= '0;
      sat <= 1'b0;
    end else if (state == FINISH) begin
      z   <= z_next;
      sat <= sat_next;
    end
  end

endmodule

// File: tb/tb_mlp_output_neuron_mac.sv
// Self-checking bench for mlp_output_neuron_mac.
// Random and directed runs against an integer reference model.
module tb_mlp_output_neuron_mac;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] bias = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic        [7:0]  in_act = '0;
  logic signed [7:0]  in_wgt = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [12:0] z;
  logic               sat;
  logic               busy;

  int n_checks = 0;
  int n_fail = 0;

  logic        [7:0] act_a[16];
  logic signed [7:0] wgt_a[16];

  mlp_output_neuron_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model(input int b, output int ze, output bit se);
    longint sum;
    longint q;
    sum = b;
    for (int i = 0; i < 16; i++)
      sum += longint'(int'(act_a[i])) * longint'(int'(wgt_a[i]));
    q = sum / 64;
    if ((sum % 64) != 0 && sum < 0) q = q - 1;
    se = 1'b0;
    if (q > 4095) begin q = 4095; se = 1'b1; end
    if (q < -4096) begin q = -4096; se = 1'b1; end
    ze = int'(q);
  endfunction

  task automatic fill(input int a, input int w);
    for (int i = 0; i < 16; i++) begin
      act_a[i] = 8'(a);
      wgt_a[i] = 8'(w);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      act_a[i] = 8'($urandom_range(255));
      wgt_a[i] = 8'($urandom_range(255));
    end
  endtask

  task automatic do_run(input logic signed [15:0] b, input int gap,
                        output logic signed [12:0] zo, output logic so,
                        output int edges, output bit ok);
    int  bi;
    bit  acc_b;
    bi = 0;
    edges = 0;
    bias = b;
    start = 1'b1;
    @(negedge clk);
    edges++;
    start = 1'b0;
    while (!out_valid && edges < 400) begin
      if (in_ready && bi < 16) begin
        in_valid = (gap == 0) || ($urandom_range(99) >= gap);
        in_act = act_a[bi];
        in_wgt = wgt_a[bi];
      end else begin
        in_valid = 1'b0;
      end
      acc_b = in_valid && in_ready;
      @(negedge clk);
      edges++;
      if (acc_b) bi++;
    end
    in_valid = 1'b0;
    ok = out_valid;
    zo = z;
    so = sat;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_run(input string name, input logic signed [15:0] b,
                           input int gap, input int zfix, input bit use_fix,
                           input bit sfix);
    logic signed [12:0] zo;
    logic signed [12:0] zexp;
    logic so;
    int edges, ze;
    bit se, ok;
    model(int'(b), ze, se);
    if (use_fix) begin
      ze = zfix;
      se = sfix;
    end
    zexp = 13'(ze);
    do_run(b, gap, zo, so, edges, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
    n_checks++;
    if (zo !== zexp) begin
      n_fail++;
      $display("FAIL %s z: got %0d required %0d", name, zo, zexp);
    end
    n_checks++;
    if (so !== se) begin
      n_fail++;
      $display("FAIL %s sat: got %b required %b", name, so, se);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b busy=%b required 0 0",
               name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, sat, busy} !== 4'b0 || z !== 13'sd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b ov=%b sat=%b busy=%b z=%0d required 0",
               in_ready, out_valid, sat, busy, z);
    end
  endtask

  task automatic test_t1();
    logic signed [12:0] zo;
    logic so;
    int edges;
    bit ok;
    fill(64, 64);
    do_run(16'sd0, 0, zo, so, edges, ok);
    n_checks++;
    if (!ok || zo !== 13'sd1024 || so !== 1'b0) begin
      n_fail++;
      $display("FAIL t1: ok=%b z=%0d sat=%b required 1 1024 0", ok, zo, so);
    end
    n_checks++;
    if (edges !== 18) begin
      n_fail++;
      $display("FAIL t1 latency: got %0d edges required 18", edges);
    end
    release_out();
  endtask

  task automatic test_saturate();
    fill(255, 127);
    check_run("sat_pos", 16'sd0, 0, 4095, 1'b1, 1'b1);
    fill(255, -128);
    check_run("sat_neg", 16'sd0, 0, -4096, 1'b1, 1'b1);
  endtask

  task automatic test_rounding();
    fill(0, 0);
    check_run("round63", 16'sd63, 0, 0, 1'b1, 1'b0);
    check_run("round64", 16'sd64, 0, 1, 1'b1, 1'b0);
    act_a[0] = 8'd1;
    wgt_a[0] = -8'sd1;
    check_run("floor_neg", 16'sd0, 0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic signed [15:0] b;
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      b = 16'($urandom_range(65535));
      check_run("random", b, (r % 2) * 30, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_handshake();
    logic signed [12:0] zo;
    logic so;
    int edges;
    bit ok;
    fill(64, 64);
    do_run(16'sd0, 40, zo, so, edges, ok);
    n_checks++;
    if (!ok || zo !== 13'sd1024 || so !== 1'b0) begin
      n_fail++;
      $display("FAIL hs result: ok=%b z=%0d sat=%b required 1 1024 0",
               ok, zo, so);
    end
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      start = k[0];
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || z !== zo || sat !== so ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hs hold: ov=%b z=%0d sat=%b rdy=%b busy=%b req 1 %0d %b 0 1",
                 out_valid, z, sat, in_ready, busy, zo, so);
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || z !== zo) begin
      n_fail++;
      $display("FAIL hs exit: ov=%b busy=%b z=%0d required 0 0 %0d",
               out_valid, busy, z, zo);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs start_ignored: busy=%b rdy=%b required 0 0",
               busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    fill(64, 64);
    bias = 16'sd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_act = act_a[i];
      in_wgt = wgt_a[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, sat, busy} !== 4'b0 || z !== 13'sd0) begin
      n_fail++;
      $display("FAIL mid reset: rdy=%b ov=%b sat=%b busy=%b z=%0d required 0",
               in_ready, out_valid, sat, busy, z);
    end
    check_run("after_reset", 16'sd0, 0, 1024, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic        [7:0] bb_a[3][16];
    logic signed [7:0] bb_w[3][16];
    logic signed [15:0] bb_b[3];
    int ze[3];
    bit se[3];
    int tout[3];
    logic signed [12:0] zo[3];
    logic so[3];
    int rs, rb, bi, nout, cyc, ri;
    bit take_s, take_b;
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      bb_b[r] = 16'($urandom_range(4000));
      for (int i = 0; i < 16; i++) begin
        bb_a[r][i] = act_a[i];
        bb_w[r][i] = wgt_a[i];
      end
      model(int'(bb_b[r]), ze[r], se[r]);
    end
    rs = 0; rb = 0; bi = 0; nout = 0; cyc = 0;
    out_ready = 1'b1;
    while (nout < 3 && cyc < 300) begin
      start = (rs < 3);
      bias = bb_b[(rs < 3) ? rs : 0];
      take_s = start && !busy;
      ri = (rb < 3) ? rb : 0;
      in_valid = in_ready;
      in_act = bb_a[ri][bi];
      in_wgt = bb_w[ri][bi];
      take_b = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (take_s) rs++;
      if (take_b) begin
        bi++;
        if (bi == 16) begin
          bi = 0;
          rb++;
        end
      end
      if (out_valid) begin
        tout[nout] = cyc;
        zo[nout] = z;
        so[nout] = sat;
        nout++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (nout !== 3) begin
      n_fail++;
      $display("FAIL b2b count: got %0d results required 3", nout);
    end
    for (int r = 0; r < nout; r++) begin
      n_checks++;
      if (zo[r] !== 13'(ze[r]) || so[r] !== se[r]) begin
        n_fail++;
        $display("FAIL b2b result %0d: z=%0d sat=%b required %0d %b",
                 r, zo[r], so[r], ze[r], se[r]);
      end
      if (r > 0) begin
        n_checks++;
        if (tout[r] - tout[r-1] !== 19) begin
          n_fail++;
          $display("FAIL b2b period %0d: got %0d cycles required 19",
                   r, tout[r] - tout[r-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_saturate();
    test_rounding();
    test_random();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
